flipper_input_sequencer: RTL and testbench
==========================================

# flipper_input_sequencer

Per-frame controller that turns the raw left/right key levels into a debounced, arbitrated, ramped horizontal velocity command for the flipper datapath. It sits between the keypad decode and the flipper position/drawing logic. The flipper position logic integrates `speedX` once per frame. All state advances only on `startOfFrame`, so flipper motion is frame-locked and pause-safe.

## Interface
Parameters:
- `DEBOUNCE_FRAMES`, default 2: consecutive equal frame samples needed before a key level is accepted. Legal range 1..8.
- `SPEED_STEP`, default 32: magnitude added to `speedX` per frame while ramping.
- `SPEED_MAX`, default 128: saturation magnitude of `speedX`.
- `BRAKE_STEP`, default 64: magnitude removed per frame while braking. Used only with `FLIPPER_BRAKE_EN`.

Ports:
- `clk`, in, 1: system clock. One clock domain only.
- `resetN`, in, 1: asynchronous, active-low reset.
- `startOfFrame`, in, 1: one-cycle frame strobe.
- `key4IsPressed`, in, 1: left key level.
- `key6IsPressed`, in, 1: right key level.
- `pause`, in, 1: freezes sequencing while high.
- `speedX`, out, 32 signed: velocity command. Negative means left.
- `moving`, out, 1: high while `speedX` is not 0.
- `dirLeft`, out, 1: high in RAMP_LEFT.
- `dirRight`, out, 1: high in RAMP_RIGHT.
- `stepValid`, out, 1: one-cycle pulse after each processed frame.

## Operation
- **Frame edge:** a rising `clk` edge with `startOfFrame` high and `pause` low. No state changes on any other edge, except reset.
- **Debounce:** at each frame edge, each key is shifted into a `DEBOUNCE_FRAMES`-deep history. The debounced level `dbL`/`dbR` updates only when all history bits are equal.
- **Arbitration:** last-pressed wins.
  - A newly debounced rising key takes ownership.
  - If both rise on the same frame edge, ownership does not change.
  - If the owner releases while the other key is held, ownership passes to the other key.
- **FSM states:** IDLE, RAMP_LEFT, RAMP_RIGHT, BRAKE.
  - IDLE: if owner is left, go to RAMP_LEFT; if owner is right, go to RAMP_RIGHT.
  - RAMP_LEFT: `speedX` is reduced by `SPEED_STEP` per frame, saturating at −`SPEED_MAX`.
  - RAMP_RIGHT: `speedX` is increased by `SPEED_STEP` per frame, saturating at +`SPEED_MAX`.
  - Owner release with no key held, or ownership reversal: go to BRAKE.
  - BRAKE: `speedX` moves toward 0 by `BRAKE_STEP`, clamping at 0 (no sign overshoot). At 0, go to IDLE, or straight to the owner's RAMP state if a key is owned.
- **Arithmetic:** 32-bit signed. Saturation is compared before the add, so no wrap-around can occur.
- **Pause:**
  - All registers hold, `speedX` included.
  - Key history is not sampled.
  - `stepValid` stays low.
  - After `pause` drops, processing resumes at the next frame edge with the pre-pause history.

## Timing
- **Reset values:** `speedX` = 0, `moving` = 0, `dirLeft` = 0, `dirRight` = 0, `stepValid` = 0. State = IDLE, histories all 0, owner = none.
- **Press latency:** a key held from frame edge k is debounced at edge k+`DEBOUNCE_FRAMES`−1.
  - The FSM acts on the registered debounced level at edge k+`DEBOUNCE_FRAMES`.
  - `speedX` = ±`SPEED_STEP` after that edge.
- **stepValid:** pulses on the clock cycle immediately after each frame edge. Outputs are already updated in that cycle.
- **Outputs:** all registered; no combinational path from inputs to outputs.
- **Reset mid-ramp:** asynchronous clear to the reset values above. The first frame after reset behaves exactly as after power-up.
- **startOfFrame and pause high together:** the edge is ignored, not a frame edge.

## Configuration
- `FLIPPER_BRAKE_EN` defined:
  - The BRAKE state exists and deceleration uses `BRAKE_STEP` as described.
- `FLIPPER_BRAKE_EN` undefined:
  - BRAKE is compiled out and `BRAKE_STEP` is unused.
  - Release or reversal sets `speedX` to 0 on that frame edge.
  - The FSM goes to IDLE, or directly to the new owner's RAMP state, which applies its first `SPEED_STEP` on the next frame edge.

## Structure
- **Shared package `flipper_pkg`:**
  - typedef `flipper_state_t` (IDLE, RAMP_LEFT, RAMP_RIGHT, BRAKE)
  - typedef `flipper_owner_t` (NONE, LEFT, RIGHT)
  - speed width constant `FLIPPER_SPEED_W` = 32
- **Sub-module `frame_key_debouncer`:** one key, frame-strobed shift history, debounced level plus rising/falling pulses. Instantiated twice.
- **Top level:** arbitration, FSM and speed datapath.

## Test plan
Defaults throughout.
- **Press and hold:** hold key4 from frame 0. Required: `speedX` = −32 after frame 2, −64 after frame 3, saturating at −128 from frame 5. `dirLeft` = 1.
- **Glitch rejection:** key6 high for exactly one frame sample. Required: `speedX` stays 0 and `stepValid` keeps pulsing every frame.
- **Reversal:** hold key4 until `speedX` = −128, then also press key6.
  - With `FLIPPER_BRAKE_EN`: −64, then 0, then +32, +64, and so on.
  - Without it: 0 on the first frame edge, then +32 on the following one.
- **Simultaneous press:** key4 and key6 rise together from IDLE. Required: no ownership, `speedX` = 0. Then release key4: ownership passes to right and `speedX` = +32 one frame later.
- **Pause:** assert `pause` at `speedX` = −64 for 10 frames. Required: `speedX` holds −64 and `stepValid` stays 0. After release, the next frame gives −96.
- **Reset mid-ramp:** drive `resetN` low asynchronously while `speedX` = +96. Required: all outputs 0 immediately. After release with no key held, `speedX` stays 0.

Source files
------------

// File: rtl/flipper_pkg.sv
// Shared types, speed width and saturating speed helpers for the flipper input sequencer.
package flipper_pkg;

   localparam int FLIPPER_SPEED_W = 32;

   typedef logic signed [FLIPPER_SPEED_W-1:0] speed_t;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      RAMP_LEFT  = 2'd1,
      RAMP_RIGHT = 2'd2,
      BRAKE      = 2'd3
   } flipper_state_t;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } flipper_owner_t;

   // Limits are checked before the add so the 32-bit result can never wrap.
   function automatic speed_t ramp_up(input speed_t s, input speed_t step, input speed_t lim);
      speed_t r;
      if (s > lim - step) r = lim;
      else                r = s + step;
      return r;
   endfunction

   function automatic speed_t ramp_down(input speed_t s, input speed_t step, input speed_t lim);
      speed_t r;
      if (s < step - lim) r = -lim;
      else                r = s - step;
      return r;
   endfunction

   function automatic speed_t toward_zero(input speed_t s, input speed_t step);
      speed_t r;
      if (s > step)       r = s - step;
      else if (s < -step) r = s + step;
      else                r = 32'sd0;
      return r;
   endfunction

   function automatic flipper_state_t owner_to_state(input flipper_owner_t o);
      flipper_state_t r;
      case (o)
         LEFT:    r = RAMP_LEFT;
         RIGHT:   r = RAMP_RIGHT;
         default: r = IDLE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/frame_key_debouncer.sv
// One key: frame-strobed shift history, debounced level and rise/fall flags.
// Rise/fall stay valid from the frame edge that set them until the next frame edge.
module frame_key_debouncer
   import flipper_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic resetN,
   input  logic i_frame,
   input  logic i_key,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [DEPTH-1:0] r_hist;
   logic [DEPTH-1:0] w_hist_next;
   logic             r_level;
   logic             r_rise;
   logic             r_fall;

   assign w_hist_next = (r_hist << 1) | DEPTH'(i_key);

   // History shift and level acceptance happen only on frame edges.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_hist  <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else if (i_frame) begin
         r_hist <= w_hist_next;
         if (&w_hist_next) begin
            r_level <= 1'b1;
            r_rise  <= ~r_level;
            r_fall  <= 1'b0;
         end else if (~|w_hist_next) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= r_level;
         end else begin
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
         end
      end else begin
         r_hist  <= r_hist;
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/flipper_input_sequencer.sv
// Frame-locked key arbitration, direction FSM and ramped speedX command.
// Optional FLIPPER_BRAKE_EN: gradual BRAKE_STEP deceleration instead of an instant stop.
module flipper_input_sequencer
   import flipper_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 2,
   parameter int SPEED_STEP      = 32,
   parameter int SPEED_MAX       = 128,
   parameter int BRAKE_STEP      = 64
) (
   input  logic                              clk,
   input  logic                              resetN,
   input  logic                              startOfFrame,
   input  logic                              key4IsPressed,
   input  logic                              key6IsPressed,
   input  logic                              pause,
   output logic signed [FLIPPER_SPEED_W-1:0] speedX,
   output logic                              moving,
   output logic                              dirLeft,
   output logic                              dirRight,
   output logic                              stepValid
);

   logic           w_frame;
   logic           w_lvl_l, w_rise_l, w_fall_l;
   logic           w_lvl_r, w_rise_r, w_fall_r;
   flipper_owner_t r_owner, w_owner_next;
   flipper_state_t r_state, w_state_next, w_rel_state;
   speed_t         r_speed, w_speed_next, w_rel_speed;
   logic           r_moving, r_dir_left, r_dir_right, r_step_valid;

   assign w_frame = startOfFrame & ~pause;

   frame_key_debouncer #(.DEPTH(DEBOUNCE_FRAMES)) u_db_left (
      .clk(clk), .resetN(resetN), .i_frame(w_frame), .i_key(key4IsPressed),
      .o_level(w_lvl_l), .o_rise(w_rise_l), .o_fall(w_fall_l)
   );

   frame_key_debouncer #(.DEPTH(DEBOUNCE_FRAMES)) u_db_right (
      .clk(clk), .resetN(resetN), .i_frame(w_frame), .i_key(key6IsPressed),
      .o_level(w_lvl_r), .o_rise(w_rise_r), .o_fall(w_fall_r)
   );

   // Last-pressed wins; a lone held key is adopted when nobody owns (after a tied press).
   always_comb begin
      w_owner_next = r_owner;
      if (w_rise_l && !w_rise_r)              w_owner_next = LEFT;
      else if (w_rise_r && !w_rise_l)         w_owner_next = RIGHT;
      else if (r_owner == LEFT && w_fall_l)   w_owner_next = w_lvl_r ? RIGHT : NONE;
      else if (r_owner == RIGHT && w_fall_r)  w_owner_next = w_lvl_l ? LEFT : NONE;
      else if (r_owner == NONE && (w_lvl_l ^ w_lvl_r))
                                              w_owner_next = w_lvl_l ? LEFT : RIGHT;
      else                                    w_owner_next = r_owner;
   end

   // Response to a release or reversal, shared by both ramp states and BRAKE.
`ifdef FLIPPER_BRAKE_EN
   always_comb begin
      w_rel_speed = toward_zero(r_speed, BRAKE_STEP);
      if (w_rel_speed == 32'sd0) w_rel_state = owner_to_state(w_owner_next);
      else                       w_rel_state = BRAKE;
   end
`else
   always_comb begin
      w_rel_speed = 32'sd0;
      w_rel_state = owner_to_state(w_owner_next);
   end
`endif

   // Next-state and speed decision for the coming frame edge.
   always_comb begin
      w_state_next = r_state;
      w_speed_next = r_speed;
      case (r_state)
         IDLE: begin
            if (w_owner_next == LEFT) begin
               w_state_next = RAMP_LEFT;
               w_speed_next = ramp_down(r_speed, SPEED_STEP, SPEED_MAX);
            end else if (w_owner_next == RIGHT) begin
               w_state_next = RAMP_RIGHT;
               w_speed_next = ramp_up(r_speed, SPEED_STEP, SPEED_MAX);
            end else begin
               w_state_next = IDLE;
               w_speed_next = 32'sd0;
            end
         end
         RAMP_LEFT: begin
            if (w_owner_next == LEFT) begin
               w_state_next = RAMP_LEFT;
               w_speed_next = ramp_down(r_speed, SPEED_STEP, SPEED_MAX);
            end else begin
               w_state_next = w_rel_state;
               w_speed_next = w_rel_speed;
            end
         end
         RAMP_RIGHT: begin
            if (w_owner_next == RIGHT) begin
               w_state_next = RAMP_RIGHT;
               w_speed_next = ramp_up(r_speed, SPEED_STEP, SPEED_MAX);
            end else begin
               w_state_next = w_rel_state;
               w_speed_next = w_rel_speed;
            end
         end
`ifdef FLIPPER_BRAKE_EN
         BRAKE: begin
            w_state_next = w_rel_state;
            w_speed_next = w_rel_speed;
         end
`endif
         default: begin
            w_state_next = IDLE;
            w_speed_next = 32'sd0;
         end
      endcase
   end

   // All sequencing state and outputs advance together on frame edges only.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state      <= IDLE;
         r_owner      <= NONE;
         r_speed      <= 32'sd0;
         r_moving     <= 1'b0;
         r_dir_left   <= 1'b0;
         r_dir_right  <= 1'b0;
         r_step_valid <= 1'b0;
      end else if (w_frame) begin
         r_state      <= w_state_next;
         r_owner      <= w_owner_next;
         r_speed      <= w_speed_next;
         r_moving     <= (w_speed_next != 32'sd0);
         r_dir_left   <= (w_state_next == RAMP_LEFT);
         r_dir_right  <= (w_state_next == RAMP_RIGHT);
         r_step_valid <= 1'b1;
      end else begin
         r_step_valid <= 1'b0;
      end
   end

   assign speedX    = r_speed;
   assign moving    = r_moving;
   assign dirLeft   = r_dir_left;
   assign dirRight  = r_dir_right;
   assign stepValid = r_step_valid;

endmodule

// File: tb/tb_flipper_input_sequencer.sv
// Scoreboard bench for flipper_input_sequencer with default parameters.
module tb_flipper_input_sequencer;

   logic              clk = 1'b0;
   logic              resetN = 1'b0;
   logic              startOfFrame = 1'b0;
   logic              key4 = 1'b0;
   logic              key6 = 1'b0;
   logic              pause = 1'b0;
   logic signed [31:0] speedX;
   logic              moving, dirLeft, dirRight, stepValid;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic signed [31:0] spd;
      logic               dl;
      logic               dr;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   flipper_input_sequencer dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .key4IsPressed(key4), .key6IsPressed(key6), .pause(pause),
      .speedX(speedX), .moving(moving), .dirLeft(dirLeft),
      .dirRight(dirRight), .stepValid(stepValid)
   );

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   // Monitor: every stepValid pulse consumes one expected frame result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (stepValid === 1'b1) begin
            check("step_pending", 32'(exp_q.size() != 0), 32'sd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("speedX",   speedX,   e.spd);
               check("moving",   32'(moving), 32'(e.spd != 32'sd0));
               check("dirLeft",  32'(dirLeft),  32'(e.dl));
               check("dirRight", 32'(dirRight), 32'(e.dr));
            end
         end
      end
   end

   task automatic frame(input logic k4, input logic k6, input int spd,
                        input logic dl, input logic dr);
      exp_t e;
      @(negedge clk);
      key4 = k4;
      key6 = k6;
      startOfFrame = 1'b1;
      e.spd = spd;
      e.dl  = dl;
      e.dr  = dr;
      exp_q.push_back(e);
      @(negedge clk);
      startOfFrame = 1'b0;
      @(negedge clk);
   endtask

   task automatic paused_frame(input int hold_spd);
      @(negedge clk);
      pause = 1'b1;
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      check("pause_stepValid", 32'(stepValid), 32'sd0);
      check("pause_speedX", speedX, hold_spd);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_speedX"},    speedX, 32'sd0);
      check({tag, "_moving"},    32'(moving), 32'sd0);
      check({tag, "_dirLeft"},   32'(dirLeft), 32'sd0);
      check({tag, "_dirRight"},  32'(dirRight), 32'sd0);
      check({tag, "_stepValid"}, 32'(stepValid), 32'sd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      key4 = 1'b0;
      key6 = 1'b0;
      pause = 1'b0;
      resetN = 1'b0;
      #2;
      check_all_zero("reset");
      @(negedge clk);
      resetN = 1'b1;
   endtask

   initial begin
      #12;
      check_all_zero("power_on");
      @(negedge clk);
      resetN = 1'b1;

      // Press and hold key4, then add key6 for a reversal.
      frame(1'b1, 1'b0,    0, 1'b0, 1'b0);
      frame(1'b1, 1'b0,    0, 1'b0, 1'b0);
      frame(1'b1, 1'b0,  -32, 1'b1, 1'b0);
      frame(1'b1, 1'b0,  -64, 1'b1, 1'b0);
      frame(1'b1, 1'b0,  -96, 1'b1, 1'b0);
      frame(1'b1, 1'b0, -128, 1'b1, 1'b0);
      frame(1'b1, 1'b0, -128, 1'b1, 1'b0);
      frame(1'b1, 1'b1, -128, 1'b1, 1'b0);
      frame(1'b1, 1'b1, -128, 1'b1, 1'b0);
`ifdef FLIPPER_BRAKE_EN
      frame(1'b1, 1'b1,  -64, 1'b0, 1'b0);
      frame(1'b1, 1'b1,    0, 1'b0, 1'b1);
`else
      frame(1'b1, 1'b1,    0, 1'b0, 1'b1);
`endif
      frame(1'b1, 1'b1,   32, 1'b0, 1'b1);
      frame(1'b1, 1'b1,   64, 1'b0, 1'b1);
      do_reset();

      // One-sample glitch on key6.
      frame(1'b0, 1'b1, 0, 1'b0, 1'b0);
      frame(1'b0, 1'b0, 0, 1'b0, 1'b0);
      frame(1'b0, 1'b0, 0, 1'b0, 1'b0);
      frame(1'b0, 1'b0, 0, 1'b0, 1'b0);

      // Simultaneous press, then key4 released: right takes over.
      frame(1'b1, 1'b1,  0, 1'b0, 1'b0);
      frame(1'b1, 1'b1,  0, 1'b0, 1'b0);
      frame(1'b1, 1'b1,  0, 1'b0, 1'b0);
      frame(1'b0, 1'b1,  0, 1'b0, 1'b0);
      frame(1'b0, 1'b1,  0, 1'b0, 1'b0);
      frame(1'b0, 1'b1, 32, 1'b0, 1'b1);
      frame(1'b0, 1'b1, 64, 1'b0, 1'b1);
      do_reset();

      // Pause at -64 for ten frames.
      frame(1'b1, 1'b0,   0, 1'b0, 1'b0);
      frame(1'b1, 1'b0,   0, 1'b0, 1'b0);
      frame(1'b1, 1'b0, -32, 1'b1, 1'b0);
      frame(1'b1, 1'b0, -64, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) paused_frame(-64);
      @(negedge clk);
      pause = 1'b0;
      frame(1'b1, 1'b0, -96, 1'b1, 1'b0);
      do_reset();

      // Asynchronous reset while ramping right at +96.
      frame(1'b0, 1'b1,  0, 1'b0, 1'b0);
      frame(1'b0, 1'b1,  0, 1'b0, 1'b0);
      frame(1'b0, 1'b1, 32, 1'b0, 1'b1);
      frame(1'b0, 1'b1, 64, 1'b0, 1'b1);
      frame(1'b0, 1'b1, 96, 1'b0, 1'b1);
      @(negedge clk);
      #2;
      resetN = 1'b0;
      key6 = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      resetN = 1'b1;
      for (int i = 0; i < 4; i++) frame(1'b0, 1'b0, 0, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'sd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
